dmem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single data-memory port. Shares the word-addressed D-memory interface between the pipeline memory stage (CPU) and a secondary bus master (DMA). Locks the port to one owner across memory wait states and produces the CPU `memory_stall` condition. Sits between the stage-4 memory logic and the data memory/cache.

---
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU request, DMA request and memory-side signals.
// The arbiter takes the slave view; the surrounding pipeline/DMA/memory take the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              cpu_ren;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_wen;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wen, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wen, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_stall
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the CPU memory stage and a DMA master, locking across wait states.
// Define DMEM_ARB_FAIRNESS_EN to compile in the DMA starvation counter and priority override.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CPU_LOCK, S_DMA_LOCK} state_t;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_DMA} grant_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_t state_q, state_d;
  grant_t grant;
  grant_t port_gnt;
  logic   cpu_req;
  logic   dma_priority;

  assign cpu_req = bus.cpu_ren | bus.cpu_wen;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q;

  assign dma_priority = bus.dma_req && (starve_cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt_q <= 4'd0;
    else if (grant == G_DMA)
      starve_cnt_q <= 4'd0;
    else if (bus.dma_req && starve_cnt_q < LIMIT)
      starve_cnt_q <= starve_cnt_q + 4'd1;
  end
`else
  assign dma_priority = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    grant   = G_NONE;
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE: begin
        if (dma_priority)     grant = G_DMA;
        else if (cpu_req)     grant = G_CPU;
        else if (bus.dma_req) grant = G_DMA;
      end
      S_CPU_LOCK: grant = G_CPU;
      S_DMA_LOCK: grant = G_DMA;
      default:    grant = G_NONE;
    endcase
    if (bus.mem_stall) begin
      if (grant == G_CPU)      state_d = S_CPU_LOCK;
      else if (grant == G_DMA) state_d = S_DMA_LOCK;
    end
  end

  // Reset gates only the output path: the flops already hold IDLE, and keeping rst_n
  // out of their D logic avoids mixing it as both async reset and sync data.
  assign port_gnt = rst_n ? grant : G_NONE;

  always_comb begin
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = ADDR_ZERO;
    bus.mem_wdata = DATA_ZERO;
    bus.dma_gnt   = 1'b0;
    bus.dma_done  = 1'b0;
    unique case (port_gnt)
      G_CPU: begin
        bus.mem_wen   = bus.cpu_wen;
        bus.mem_ren   = bus.cpu_ren & ~bus.cpu_wen;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      G_DMA: begin
        bus.mem_wen   = bus.dma_wen;
        bus.mem_ren   = ~bus.dma_wen;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.dma_gnt   = 1'b1;
        bus.dma_done  = ~bus.mem_stall;
      end
      default: ;
    endcase
  end

  assign bus.cpu_stall = rst_n && cpu_req && !(port_gnt == G_CPU && !bus.mem_stall);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: expectations queued at stimulus time, popped at each sample point.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic fair;

  initial begin
    bus.cpu_ren = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_wen = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0; bus.mem_stall = 1'b0;

    // Reset asserted with a CPU request pending: everything forced quiet.
    bus.cpu_ren = 1'b1; bus.cpu_addr = 30'h10;
    #2;
    push("rst_mem_ren", 64'd0); push("rst_cpu_stall", 64'd0); push("rst_mem_addr", 64'd0);
    check(64'(bus.mem_ren)); check(64'(bus.cpu_stall)); check(64'(bus.mem_addr));
    @(negedge clk);
    rst_n = 1'b1; bus.cpu_ren = 1'b0;
    next_cycle();

    // Zero-wait CPU load.
    bus.cpu_ren = 1'b1; bus.cpu_addr = 30'h10; bus.mem_rdata = 32'hDEAD_BEEF;
    push("ld_mem_ren", 64'd1); push("ld_mem_wen", 64'd0); push("ld_mem_addr", 64'h10);
    push("ld_cpu_stall", 64'd0); push("ld_cpu_rdata", 64'hDEAD_BEEF);
    @(negedge clk);
    check(64'(bus.mem_ren)); check(64'(bus.mem_wen)); check(64'(bus.mem_addr));
    check(64'(bus.cpu_stall)); check(64'(bus.cpu_rdata));
    next_cycle();
    bus.cpu_ren = 1'b0;

    // CPU store with three wait states; DMA arriving mid-lock is refused.
    for (int i = 0; i < 4; i++) begin
      bus.cpu_wen = 1'b1; bus.cpu_addr = 30'h20; bus.cpu_wdata = 32'h1234_5678;
      bus.mem_stall = (i < 3);
      if (i == 1) begin
        bus.dma_req = 1'b1; bus.dma_wen = 1'b0; bus.dma_addr = 30'h40;
      end
      push($sformatf("st_cpu_stall_c%0d", i), 64'(i < 3));
      push($sformatf("st_mem_wen_c%0d", i), 64'd1);
      push($sformatf("st_mem_addr_c%0d", i), 64'h20);
      push($sformatf("st_mem_wdata_c%0d", i), 64'h1234_5678);
      push($sformatf("st_dma_gnt_c%0d", i), 64'd0);
      @(negedge clk);
      check(64'(bus.cpu_stall)); check(64'(bus.mem_wen)); check(64'(bus.mem_addr));
      check(64'(bus.mem_wdata)); check(64'(bus.dma_gnt));
      next_cycle();
    end
    bus.cpu_wen = 1'b0;

    // DMA read with two wait states; CPU load raised on the second grant cycle.
    for (int j = 0; j < 3; j++) begin
      bus.mem_stall = (j < 2);
      bus.mem_rdata = 32'hCAFE_0040;
      if (j == 1) begin
        bus.cpu_ren = 1'b1; bus.cpu_addr = 30'h50;
      end
      push($sformatf("dma_gnt_c%0d", j), 64'd1);
      push($sformatf("dma_done_c%0d", j), 64'(j == 2));
      push($sformatf("dma_mem_ren_c%0d", j), 64'd1);
      push($sformatf("dma_mem_addr_c%0d", j), 64'h40);
      push($sformatf("dma_cpu_stall_c%0d", j), 64'(j >= 1));
      push($sformatf("dma_rdata_c%0d", j), 64'hCAFE_0040);
      @(negedge clk);
      check(64'(bus.dma_gnt)); check(64'(bus.dma_done)); check(64'(bus.mem_ren));
      check(64'(bus.mem_addr)); check(64'(bus.cpu_stall)); check(64'(bus.dma_rdata));
      next_cycle();
    end
    bus.dma_req = 1'b0; bus.mem_rdata = 32'h5050_5050;
    push("post_dma_cpu_stall", 64'd0); push("post_dma_gnt", 64'd0);
    push("post_dma_mem_addr", 64'h50); push("post_dma_cpu_rdata", 64'h5050_5050);
    @(negedge clk);
    check(64'(bus.cpu_stall)); check(64'(bus.dma_gnt)); check(64'(bus.mem_addr));
    check(64'(bus.cpu_rdata));
    next_cycle();

    // Continuous CPU and DMA contention without memory stalls.
    bus.dma_req = 1'b1; bus.dma_wen = 1'b1; bus.dma_addr = 30'h60; bus.dma_wdata = 32'h6060_6060;
    bus.mem_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef DMEM_ARB_FAIRNESS_EN
      fair = (k == 4) || (k == 9);
`else
      fair = 1'b0;
`endif
      push($sformatf("fair_dma_gnt_c%0d", k), 64'(fair));
      push($sformatf("fair_dma_done_c%0d", k), 64'(fair));
      push($sformatf("fair_cpu_stall_c%0d", k), 64'(fair));
      push($sformatf("fair_mem_wen_c%0d", k), 64'(fair));
      push($sformatf("fair_mem_addr_c%0d", k), fair ? 64'h60 : 64'h50);
      @(negedge clk);
      check(64'(bus.dma_gnt)); check(64'(bus.dma_done)); check(64'(bus.cpu_stall));
      check(64'(bus.mem_wen)); check(64'(bus.mem_addr));
      next_cycle();
    end
    bus.cpu_ren = 1'b0; bus.dma_req = 1'b0;
    next_cycle();

    // Reset pulse in the middle of a DMA lock.
    bus.dma_req = 1'b1; bus.dma_wen = 1'b1; bus.dma_addr = 30'h70; bus.dma_wdata = 32'h7070_7070;
    bus.mem_stall = 1'b1;
    push("lock_dma_gnt0", 64'd1); push("lock_mem_wen0", 64'd1);
    @(negedge clk);
    check(64'(bus.dma_gnt)); check(64'(bus.mem_wen));
    next_cycle();
    bus.cpu_ren = 1'b1; bus.cpu_addr = 30'h80;
    #1;
    push("lock_dma_gnt1", 64'd1); push("lock_cpu_stall1", 64'd1);
    check(64'(bus.dma_gnt)); check(64'(bus.cpu_stall));
    #1;
    rst_n = 1'b0;
    #1;
    push("arst_mem_wen", 64'd0); push("arst_mem_ren", 64'd0); push("arst_dma_gnt", 64'd0);
    push("arst_cpu_stall", 64'd0); push("arst_mem_addr", 64'd0);
    check(64'(bus.mem_wen)); check(64'(bus.mem_ren)); check(64'(bus.dma_gnt));
    check(64'(bus.cpu_stall)); check(64'(bus.mem_addr));
    bus.dma_req = 1'b0; bus.mem_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("rel_mem_ren", 64'd1); push("rel_cpu_stall", 64'd0);
    push("rel_mem_addr", 64'h80); push("rel_dma_gnt", 64'd0);
    check(64'(bus.mem_ren)); check(64'(bus.cpu_stall)); check(64'(bus.mem_addr));
    check(64'(bus.dma_gnt));
    next_cycle();

    // Load and store together: the store wins.
    bus.cpu_ren = 1'b1; bus.cpu_wen = 1'b1; bus.cpu_addr = 30'h90; bus.cpu_wdata = 32'h9090_9090;
    push("rw_mem_wen", 64'd1); push("rw_mem_ren", 64'd0);
    push("rw_cpu_stall", 64'd0); push("rw_mem_addr", 64'h90);
    @(negedge clk);
    check(64'(bus.mem_wen)); check(64'(bus.mem_ren)); check(64'(bus.cpu_stall));
    check(64'(bus.mem_addr));
    next_cycle();
    bus.cpu_ren = 1'b0; bus.cpu_wen = 1'b0;
    push("idle_mem_wen", 64'd0); push("idle_dma_gnt", 64'd0);
    @(negedge clk);
    check(64'(bus.mem_wen)); check(64'(bus.dma_gnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
